// File: rtl/pipelined_signed_addsub.sv
// Pipelined two's-complement adder/subtractor: one CHUNK-bit slice per stage, carry
// registered between stages, operands skewed in and result slices deskewed out.
module pipelined_signed_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int STAGES = WIDTH / CHUNK;

  if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("pipelined_signed_addsub: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;

  // A single enable freezes every stage, so carries and valid bits never slip apart.
  assign in_ready = !out_valid || out_ready;
  assign adv      = in_ready;
  assign b_eff    = b ^ {WIDTH{sub}};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int RW = (k + 1) * CHUNK;

    logic             vin;
    logic             cin;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   sum;
    logic [RW-1:0]    res_d;
    logic             valid_q;
    logic             carry_q;
    logic [RW-1:0]    res_q;

    if (k == 0) begin : g_in
      assign vin   = in_valid;
      assign cin   = sub;
      assign a_sl  = a[CHUNK-1:0];
      assign b_sl  = b_eff[CHUNK-1:0];
      assign res_d = sum[CHUNK-1:0];
    end else begin : g_chain
      assign vin   = g_stage[k-1].valid_q;
      assign cin   = g_stage[k-1].carry_q;
      assign a_sl  = g_stage[k-1].g_skew.a_q[CHUNK-1:0];
      assign b_sl  = g_stage[k-1].g_skew.b_q[CHUNK-1:0];
      assign res_d = {sum[CHUNK-1:0], g_stage[k-1].res_q};
    end

    assign sum = {1'b0, a_sl} + {1'b0, b_sl} + (CHUNK + 1)'(cin);

    // NOTE: sequential state uses non-blocking assignment so every stage samples
    // its predecessor's pre-edge value, independent of process evaluation order.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        res_q   <= '0;
      end else if (adv) begin
        valid_q <= vin;
        carry_q <= sum[CHUNK];
        res_q   <= res_d;
      end
    end

    // Unconsumed upper operand slices ride along, dropping one slice per stage.
    if (k < STAGES - 1) begin : g_skew
      localparam int OW = WIDTH - RW;

      logic [OW-1:0] a_d;
      logic [OW-1:0] b_d;
      logic [OW-1:0] a_q;
      logic [OW-1:0] b_q;

      if (k == 0) begin : g_src_in
        assign a_d = a[WIDTH-1:CHUNK];
        assign b_d = b_eff[WIDTH-1:CHUNK];
      end else begin : g_src_prev
        assign a_d = g_stage[k-1].g_skew.a_q[OW+CHUNK-1:CHUNK];
        assign b_d = g_stage[k-1].g_skew.b_q[OW+CHUNK-1:CHUNK];
      end

      // NOTE: data/skew registers are reset too, so a reset leaves no stale operand
      // bits anywhere in the pipe, not just cleared valid bits.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_msb
      logic msbc_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          msbc_q <= 1'b0;
        end else if (adv) begin
          msbc_q <= a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ sum[CHUNK-1];
        end
      end
    end
  end

  logic             last_valid;
  logic             last_carry;
  logic             last_msbc;
  logic [WIDTH-1:0] last_res;

  assign last_valid = g_stage[STAGES-1].valid_q;
  assign last_carry = g_stage[STAGES-1].carry_q;
  assign last_msbc  = g_stage[STAGES-1].g_msb.msbc_q;
  assign last_res   = g_stage[STAGES-1].res_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_q;
  logic             cout_q;
  logic             overflow_q;
  logic             zero_q;
  logic             negative_q;

  // Result registers only load on real beats, so bubbles leave the last result visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      cout_q      <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
    end else if (adv) begin
      out_valid_q <= last_valid;
      if (last_valid) begin
        out_q      <= last_res;
        cout_q     <= last_carry;
        overflow_q <= last_msbc ^ last_carry;
        zero_q     <= (last_res == '0);
        negative_q <= last_res[WIDTH-1];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;

endmodule

// File: tb/tb_pipelined_signed_addsub.sv
// Scoreboard bench for pipelined_signed_addsub: directed vectors with hand-computed
// results, decoupled driver and monitor, stall and mid-flight reset scenarios.
module tb_pipelined_signed_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out;
  logic        cout;
  logic        overflow;
  logic        zero;
  logic        negative;

  pipelined_signed_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .cout(cout), .overflow(overflow), .zero(zero), .negative(negative)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] o;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } res_t;

  typedef struct {
    res_t r;
    int   acc;
    bit   lat;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] o;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } vec_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge whenever both are high here.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out: got out=0x%0h with empty scoreboard", out);
      end else begin
        e = sbq.pop_front();
        check("result{out,cout,ovf,zero,neg}", {12'd0, out, cout, overflow, zero, negative},
              {12'd0, e.r});
        if (e.lat) check("latency", cyc - e.acc, 4);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input vec_t t, input bit lat);
    exp_t e;
    int   budget;
    budget = 0;
    a = t.a;
    b = t.b;
    sub = t.s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      budget++;
      if (budget > 50) begin
        n_cmp++;
        n_fail++;
        $display("FAIL issue_timeout: in_ready stuck at 0 for a=0x%0h", t.a);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    e.r   = '{o: t.o, c: t.c, v: t.v, z: t.z, n: t.n};
    e.acc = cyc + 1;
    e.lat = lat;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  vec_t dir_v[5] = '{
    '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0},
    '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1},
    '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0},
    '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1},
    '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1}
  };

  vec_t b2b_v[8] = '{
    '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0},
    '{16'h1234, 16'h0234, 1'b1, 16'h1000, 1'b1, 1'b0, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0},
    '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1},
    '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0},
    '{16'h00F0, 16'h000F, 1'b1, 16'h00E1, 1'b1, 1'b0, 1'b0, 1'b0},
    '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0},
    '{16'h4000, 16'hC000, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1}
  };

  vec_t stall_v[6] = '{
    '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0},
    '{16'h0010, 16'h0020, 1'b1, 16'hFFF0, 1'b0, 1'b0, 1'b0, 1'b1},
    '{16'h7000, 16'h1000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1},
    '{16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0},
    '{16'h1111, 16'hEEEF, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0},
    '{16'h0100, 16'h0001, 1'b1, 16'h00FF, 1'b1, 1'b0, 1'b0, 1'b0}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [20:0] snap;
    int          t;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_outputs", {11'd0, out_valid, out, cout, overflow, zero, negative}, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed corner vectors, one at a time.
    for (int i = 0; i < 5; i++) begin
      issue(dir_v[i], 1'b1);
      drain();
    end

    // Eight back-to-back beats; the latency check on each implies a gapless stream.
    for (int i = 0; i < 8; i++) issue(b2b_v[i], 1'b1);
    drain();

    // Stream with a downstream stall of several cycles in the middle.
    fork
      begin
        for (int i = 0; i < 6; i++) issue(stall_v[i], 1'b0);
      end
      begin
        t = 0;
        while (!out_valid && t < 50) begin
          @(negedge clk);
          t++;
        end
        check("stall_saw_output", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        snap = {out_valid, out, cout, overflow, zero, negative};
        check("stall_in_ready", in_ready, 0);
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_hold", {11'd0, out_valid, out, cout, overflow, zero, negative},
                {11'd0, snap});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight: none of them may ever come out.
    issue(dir_v[0], 1'b1);
    issue(dir_v[2], 1'b1);
    issue(dir_v[3], 1'b1);
    rst_n = 1'b0;
    sbq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {11'd0, out_valid, out, cout, overflow, zero, negative}, 0);
    repeat (8) begin
      @(negedge clk);
      check("midrst_no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;
    issue(b2b_v[7], 1'b1);
    drain();

    check("scoreboard_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
